mux_rr_sched: RTL and testbench
===============================

# mux_rr_sched

Two-lane round-robin scheduler that feeds the PHY TX 2:1 byte mux. It buffers each lane in a 4-entry FIFO, grants the shared output fairly between lanes, and presents one registered byte per cycle under a valid/ready handshake to the downstream stage. It sits directly upstream of the serializer in phy_tx and replaces direct valid_in0/valid_in1 driving of the mux.

## Interface
- DATA_W, 8, byte width per lane
- FIFO_DEPTH, 4, entries per lane FIFO (power of two)
- f2  input  1  clock, all logic on rising edge
- reset_L  input  1  reset, synchronous, active-low
- data_in0  input  DATA_W  lane 0 byte
- valid_in0  input  1  lane 0 write strobe, no backpressure
- data_in1  input  DATA_W  lane 1 byte
- valid_in1  input  1  lane 1 write strobe, no backpressure
- ready_out  input  1  downstream accepts data_out this cycle
- data_out  output  DATA_W  granted byte (registered)
- valid_out  output  1  data_out holds a valid byte
- lane_out  output  1  source lane of data_out
- full0, full1  output  1  lane FIFO holds FIFO_DEPTH entries
- overflow0, overflow1  output  1  sticky: a lane write was dropped

## Operation
- Reset (reset_L low at an edge, any time): FIFOs flushed, data_out=0, valid_out=0, lane_out=0, overflowN=0, priority pointer prio=0. Applies mid-transfer; in-flight byte is discarded.
- Write: valid_inN=1 at an edge pushes data_inN if countN<FIFO_DEPTH or laneN is popped the same edge; otherwise byte dropped, overflowN set and held until reset.
- Count width clog2(FIFO_DEPTH)+1 (0..4); read/write pointers clog2(FIFO_DEPTH) bits, wrap 3->0.
- Output register loads when !valid_out || ready_out ("load slot").
- Grant FSM, states IDLE, SEND0, SEND1 (state = lane loaded into output register last edge):
  - load slot, both lanes non-empty: grant lane prio; prio toggles.
  - load slot, one lane non-empty: grant that lane; prio = other lane.
  - load slot, none non-empty: next state IDLE, valid_out=0, prio unchanged.
  - no load slot: state, data_out, lane_out, valid_out hold.
- Grant pops the lane FIFO, loads data_out/lane_out, sets valid_out=1, next state SEND<lane>.
- No bypass: a byte written at edge E is not visible to the grant logic until edge E+1.

## Timing
- Minimum latency: valid_inN sampled at edge E -> valid_out=1 after edge E+1.
- Throughput: one byte per cycle while ready_out=1 and any lane non-empty.
- Both lanes continuously busy: output alternates 0,1,0,1 starting with lane prio.
- valid_out and data_out stable while valid_out=1 and ready_out=0.
- fullN combinational from countN, reflects state after the last edge.

## Configuration
- MUX_RR_SCHED_STATS_EN defined: adds outputs tx_cnt0, tx_cnt1 (16 bit each), counting transfers (valid_out && ready_out) per lane_out; cleared by reset, wrap 0xFFFF->0x0000.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package mux_rr_sched_pkg: DATA_W, FIFO_DEPTH defaults, derived pointer/count widths, FSM state enum (IDLE, SEND0, SEND1).
- One sub-module: sched_fifo (single-clock FIFO with push, pop, data, count, full, empty), instantiated per lane.
- Grant FSM, priority pointer, output register and optional counters in top level.

## Test plan
- Reset then valid_in0=1 with 0xA1 for one cycle, ready_out=1 -> data_out=0xA1, lane_out=0, valid_out=1 exactly one cycle after the write edge, then valid_out=0.
- Both lanes write 3 bytes each (0x10..0x12 / 0x20..0x22), ready_out=1 -> output 0x10,0x20,0x11,0x21,0x12,0x22.
- ready_out=0, lane1 writes 6 bytes -> full1=1 after 4, 5th and 6th dropped, overflow1=1 sticky; output holds first byte until ready_out=1.
- Lane 0 full, push and pop at the same edge with ready_out=1 -> push accepted, full0 stays 1, overflow0 stays 0.
- reset_L low for one edge while both FIFOs hold data and valid_out=1 -> next cycle valid_out=0, data_out=0, full0/1=0, overflow0/1=0, next grant lane 0.
- With MUX_RR_SCHED_STATS_EN: 5 lane-0 and 3 lane-1 transfers -> tx_cnt0=5, tx_cnt1=3; stalled cycles not counted.

Source files
------------

// File: rtl/mux_rr_sched_pkg.sv
// mux_rr_sched_pkg: shared constants for the two-lane round-robin scheduler.
//   DEF_DATA_W / DEF_FIFO_DEPTH : default byte width and per-lane FIFO depth
//   DEF_PTR_W / DEF_CNT_W       : pointer and occupancy-count widths for the defaults
//   IDLE / SEND0 / SEND1        : grant FSM encodings (lane loaded into the output register)
package mux_rr_sched_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_PTR_W      = $clog2(DEF_FIFO_DEPTH);
    localparam int DEF_CNT_W      = DEF_PTR_W + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEND0 = 2'd1;
    localparam logic [1:0] SEND1 = 2'd2;

endpackage

// File: rtl/mux_rr_sched_if.sv
// mux_rr_sched_if: lane write strobes, downstream handshake and status flags
// of the scheduler.
//   master : upstream/downstream side (drives lane bytes, strobes, ready_out)
//   slave  : scheduler side (drives data_out, valid_out, lane_out, full*, overflow*)
interface mux_rr_sched_if
    import mux_rr_sched_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] data_in0;
    logic              valid_in0;
    logic [DATA_W-1:0] data_in1;
    logic              valid_in1;
    logic              ready_out;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              lane_out;
    logic              full0;
    logic              full1;
    logic              overflow0;
    logic              overflow1;

    modport master (
        output data_in0, valid_in0, data_in1, valid_in1, ready_out,
        input  data_out, valid_out, lane_out, full0, full1, overflow0, overflow1
    );

    modport slave (
        input  data_in0, valid_in0, data_in1, valid_in1, ready_out,
        output data_out, valid_out, lane_out, full0, full1, overflow0, overflow1
    );
endinterface

// File: rtl/mux_rr_sched_fifo.sv
// sched_fifo: single-clock lane FIFO for the round-robin scheduler.
//   clk, rst_n : clock and synchronous active-low reset (flushes pointers/count)
//   push, din  : write request; accepted when not full, or when popped the same edge
//   pop        : read request; ignored when empty
//   dout       : head entry (combinational from storage, so no write-to-read bypass)
//   count      : occupancy 0..DEPTH
//   full/empty : occupancy flags
module sched_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);
    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic                         wr_en;
    logic                         rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    // A full FIFO can still take a byte when its head leaves on the same edge.
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mux_rr_sched.sv
// mux_rr_sched: two-lane round-robin scheduler feeding the PHY TX 2:1 byte mux.
// Each lane is buffered in a sched_fifo; a grant FSM moves one byte per cycle
// into a registered output under valid/ready.
//   f2       : clock, rising edge
//   reset_L  : synchronous active-low reset (flushes FIFOs, output, priority, flags)
//   bus      : mux_rr_sched_if.slave (lane writes, ready_out, data/valid/lane_out,
//              full0/1, sticky overflow0/1)
//   tx_cnt0/1: per-lane transfer counters, present only when the macro
//              MUX_RR_SCHED_STATS_EN is defined
module mux_rr_sched
    import mux_rr_sched_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                f2,
    input  logic                reset_L,
    mux_rr_sched_if.slave       bus
`ifdef MUX_RR_SCHED_STATS_EN
    ,
    output logic [15:0]         tx_cnt0,
    output logic [15:0]         tx_cnt1
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [1:0][DATA_W-1:0] lane_din;
    logic [1:0][DATA_W-1:0] lane_dout;
    logic [1:0][CNT_W-1:0]  lane_cnt;
    logic [1:0]             lane_push;
    logic [1:0]             lane_pop;
    logic [1:0]             lane_full;
    logic [1:0]             lane_empty;
    logic [1:0]             lane_drop;

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic                   prio;
    logic                   prio_nxt;
    logic [DATA_W-1:0]      data_q;
    logic [1:0]             ovf_q;
    logic                   load;
    logic                   gnt_vld;
    logic                   gnt_lane;

    assign lane_din  = {bus.data_in1, bus.data_in0};
    assign lane_push = {bus.valid_in1, bus.valid_in0};

    for (genvar i = 0; i < 2; i++) begin : g_lane
        sched_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH),
            .PTR_W  (PTR_W),
            .CNT_W  (CNT_W)
        ) u_fifo (
            .clk   (f2),
            .rst_n (reset_L),
            .push  (lane_push[i]),
            .pop   (lane_pop[i]),
            .din   (lane_din[i]),
            .dout  (lane_dout[i]),
            .count (lane_cnt[i]),
            .full  (lane_full[i]),
            .empty (lane_empty[i])
        );
        assign lane_pop[i]  = gnt_vld && (gnt_lane == 1'(i));
        assign lane_drop[i] = lane_push[i] && lane_full[i] && !lane_pop[i];
    end

    // The state register is the source of valid_out/lane_out: it names the
    // lane whose byte currently sits in the output register.
    assign bus.valid_out = (state != IDLE);
    assign bus.lane_out  = (state == SEND1);
    assign bus.data_out  = data_q;
    assign bus.full0     = (lane_cnt[0] == CNT_W'(FIFO_DEPTH));
    assign bus.full1     = (lane_cnt[1] == CNT_W'(FIFO_DEPTH));
    assign bus.overflow0 = ovf_q[0];
    assign bus.overflow1 = ovf_q[1];

    assign load = (state == IDLE) || bus.ready_out;

    // Contended grant goes to prio and flips it; a lone requester is granted
    // and prio moves to the other lane so it wins the next contention.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_lane  = 1'b0;
        prio_nxt  = prio;
        state_nxt = state;
        if (load) begin
            if (!lane_empty[0] && !lane_empty[1]) begin
                gnt_vld  = 1'b1;
                gnt_lane = prio;
                prio_nxt = ~prio;
            end else if (!lane_empty[0]) begin
                gnt_vld  = 1'b1;
                gnt_lane = 1'b0;
                prio_nxt = 1'b1;
            end else if (!lane_empty[1]) begin
                gnt_vld  = 1'b1;
                gnt_lane = 1'b1;
                prio_nxt = 1'b0;
            end
            if (gnt_vld)
                state_nxt = gnt_lane ? SEND1 : SEND0;
            else
                state_nxt = IDLE;
        end
    end

    always_ff @(posedge f2) begin
        if (!reset_L) begin
            state  <= IDLE;
            prio   <= 1'b0;
            data_q <= '0;
            ovf_q  <= '0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            ovf_q <= ovf_q | lane_drop;
            if (gnt_vld)
                data_q <= lane_dout[gnt_lane];
        end
    end

`ifdef MUX_RR_SCHED_STATS_EN
    always_ff @(posedge f2) begin
        if (!reset_L) begin
            tx_cnt0 <= '0;
            tx_cnt1 <= '0;
        end else if (bus.valid_out && bus.ready_out) begin
            if (bus.lane_out)
                tx_cnt1 <= tx_cnt1 + 16'd1;
            else
                tx_cnt0 <= tx_cnt0 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mux_rr_sched.sv
module tb_mux_rr_sched;
    import mux_rr_sched_pkg::*;

    logic f2 = 1'b0;
    logic reset_L = 1'b0;
    always #5 f2 = ~f2;

    mux_rr_sched_if bus ();

`ifdef MUX_RR_SCHED_STATS_EN
    logic [15:0] tx_cnt0;
    logic [15:0] tx_cnt1;
    mux_rr_sched dut (.f2(f2), .reset_L(reset_L), .bus(bus),
                      .tx_cnt0(tx_cnt0), .tx_cnt1(tx_cnt1));
`else
    mux_rr_sched dut (.f2(f2), .reset_L(reset_L), .bus(bus));
`endif

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two byte queues, a priority bit and the output slot.
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    bit          m_vld, m_lane, m_prio, m_ovf0, m_ovf1, started;
    logic [7:0]  m_data;
    logic [15:0] m_cnt0, m_cnt1;
    bit          gnt, gl;

    always @(posedge f2) begin
        if (!reset_L) begin
            q0.delete(); q1.delete();
            m_vld = 0; m_lane = 0; m_prio = 0; m_data = 8'h00;
            m_ovf0 = 0; m_ovf1 = 0; m_cnt0 = 0; m_cnt1 = 0;
            started = 1;
        end else begin
            if (m_vld && bus.ready_out) begin
                if (m_lane) m_cnt1 += 16'd1;
                else        m_cnt0 += 16'd1;
            end
            if (!m_vld || bus.ready_out) begin
                gnt = 1; gl = 0;
                if (q0.size() > 0 && q1.size() > 0) begin gl = m_prio; m_prio = !m_prio; end
                else if (q0.size() > 0) begin gl = 0; m_prio = 1; end
                else if (q1.size() > 0) begin gl = 1; m_prio = 0; end
                else gnt = 0;
                if (gnt) begin
                    m_data = gl ? q1.pop_front() : q0.pop_front();
                    m_lane = gl;
                    m_vld  = 1;
                end else begin
                    m_vld = 0;
                end
            end
            // Pushes land after the pop, so a popped full lane has room.
            if (bus.valid_in0) begin
                if (q0.size() < DEF_FIFO_DEPTH) q0.push_back(bus.data_in0);
                else m_ovf0 = 1;
            end
            if (bus.valid_in1) begin
                if (q1.size() < DEF_FIFO_DEPTH) q1.push_back(bus.data_in1);
                else m_ovf1 = 1;
            end
        end
    end

    // Per-cycle compare plus a log of accepted transfers ({lane, byte}).
    logic [8:0] xlog[$];
    always @(negedge f2) begin
        if (started) begin
            chk("valid_out", bus.valid_out, m_vld);
            if (m_vld) begin
                chk("data_out", bus.data_out, m_data);
                chk("lane_out", bus.lane_out, m_lane);
            end
            chk("full0", bus.full0, q0.size() == DEF_FIFO_DEPTH);
            chk("full1", bus.full1, q1.size() == DEF_FIFO_DEPTH);
            chk("overflow0", bus.overflow0, m_ovf0);
            chk("overflow1", bus.overflow1, m_ovf1);
`ifdef MUX_RR_SCHED_STATS_EN
            chk("tx_cnt0", tx_cnt0, m_cnt0);
            chk("tx_cnt1", tx_cnt1, m_cnt1);
`endif
            if (bus.valid_out && bus.ready_out)
                xlog.push_back({bus.lane_out, bus.data_out});
        end
    end

    // Inputs change 2 time units after the edge; outputs are read there too.
    task automatic step(input bit v0, input logic [7:0] d0, input bit v1,
                        input logic [7:0] d1, input bit rdy);
        bus.valid_in0 = v0; bus.data_in0 = d0;
        bus.valid_in1 = v1; bus.data_in1 = d1;
        bus.ready_out = rdy;
        @(posedge f2);
        #2;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        step(0, 8'h00, 0, 8'h00, 0);
        reset_L = 1'b1;
    endtask

    task automatic chk_log(input string name, input logic [8:0] exp[$]);
        chk({name, "_len"}, xlog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < xlog.size(); i++)
            chk(name, xlog[i], exp[i]);
    endtask

    initial begin
        logic [8:0] exp[$];
        step(0, 8'h00, 0, 8'h00, 0);
        do_reset();
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_data", bus.data_out, 8'h00);
        chk("rst_lane", bus.lane_out, 0);
        chk("rst_full", {bus.full1, bus.full0}, 2'b00);
        chk("rst_ovf", {bus.overflow1, bus.overflow0}, 2'b00);

        // Single byte latency
        step(1, 8'hA1, 0, 8'h00, 1);
        chk("lat_not_yet", bus.valid_out, 0);
        step(0, 8'h00, 0, 8'h00, 1);
        chk("lat_valid", bus.valid_out, 1);
        chk("lat_data", bus.data_out, 8'hA1);
        chk("lat_lane", bus.lane_out, 0);
        step(0, 8'h00, 0, 8'h00, 1);
        chk("lat_done", bus.valid_out, 0);

        // Alternation with both lanes busy
        do_reset();
        xlog.delete();
        for (int i = 0; i < 3; i++)
            step(1, 8'h10 + 8'(i), 1, 8'h20 + 8'(i), 1);
        repeat (8) step(0, 8'h00, 0, 8'h00, 1);
        exp = '{9'h010, 9'h120, 9'h011, 9'h121, 9'h012, 9'h122};
        chk_log("rr_order", exp);

        // Overflow on lane 1 while the output stalls on a lane-0 byte
        xlog.delete();
        step(1, 8'h3F, 0, 8'h00, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 8'h00, 1, 8'h30 + 8'(k), 0);
            if (k == 3) begin
                chk("ovf_full_at4", bus.full1, 1);
                chk("ovf_not_yet", bus.overflow1, 0);
            end
        end
        chk("ovf_set", bus.overflow1, 1);
        chk("ovf_full1", bus.full1, 1);
        repeat (2) step(0, 8'h00, 0, 8'h00, 0);
        chk("stall_valid", bus.valid_out, 1);
        chk("stall_data", bus.data_out, 8'h3F);
        chk("ovf_sticky", bus.overflow1, 1);
        repeat (6) step(0, 8'h00, 0, 8'h00, 1);
        exp = '{9'h03F, 9'h130, 9'h131, 9'h132, 9'h133};
        chk_log("ovf_drain", exp);
        chk("ovf_after_drain", bus.overflow1, 1);

        // Lane 0 full: push and pop on the same edge
        step(1, 8'h40, 0, 8'h00, 0);
        for (int k = 1; k < 5; k++)
            step(1, 8'h40 + 8'(k), 0, 8'h00, 0);
        chk("pp_full_before", bus.full0, 1);
        chk("pp_data_before", bus.data_out, 8'h40);
        step(1, 8'h45, 0, 8'h00, 1);
        chk("pp_full_after", bus.full0, 1);
        chk("pp_no_ovf", bus.overflow0, 0);
        chk("pp_data_after", bus.data_out, 8'h41);

        // Reset mid-transfer with both lanes holding data
        repeat (2) step(0, 8'h00, 1, 8'h50, 0);
        do_reset();
        chk("mr_valid", bus.valid_out, 0);
        chk("mr_data", bus.data_out, 8'h00);
        chk("mr_full", {bus.full1, bus.full0}, 2'b00);
        chk("mr_ovf", {bus.overflow1, bus.overflow0}, 2'b00);
        step(1, 8'h60, 1, 8'h70, 1);
        step(0, 8'h00, 0, 8'h00, 1);
        chk("mr_first_lane", bus.lane_out, 0);
        chk("mr_first_data", bus.data_out, 8'h60);
        repeat (3) step(0, 8'h00, 0, 8'h00, 1);

`ifdef MUX_RR_SCHED_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++)
            step(1, 8'h80 + 8'(i), (i < 3), 8'h90 + 8'(i), 1);
        for (int i = 0; i < 10; i++)
            step(0, 8'h00, 0, 8'h00, bit'(i % 2));
        repeat (6) step(0, 8'h00, 0, 8'h00, 1);
        chk("stats_cnt0", tx_cnt0, 16'd5);
        chk("stats_cnt1", tx_cnt1, 16'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
